// File: rtl/rissy_regfile_sb.sv
// rissy_regfile_sb: register file with a per-register pending (scoreboard) bit.
// Reads are combinational; register 0 is hardwired to zero. Issue requests
// reserve a destination (WAW stall while it is already pending); writeback
// stores data and releases the reservation.
// Optional feature: define RISSY_RF_BYPASS_EN for same-cycle write-through
// forwarding of the writeback value onto matching read ports.
module rissy_regfile_sb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  iss_valid,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic                  iss_ready,
  output logic [ADDR_W:0]       pend_cnt,
  output logic                  idle
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pending;
  logic [ADDR_W:0]   cnt;
  logic              wr_en;
  logic              iss_fire;
  logic              wb_clr;

  // Handshake decode: iss_ready uses the pre-edge pending bit only.
  always_comb begin
    wr_en     = we && (waddr != '0);
    iss_ready = (iss_addr == '0) ? 1'b1 : !pending[iss_addr];
    iss_fire  = iss_valid && iss_ready && (iss_addr != '0);
    wb_clr    = wr_en && pending[waddr];
  end

  // Register storage; index 0 is never written so it holds zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  // Pending bits: the set is ordered after the clear so issue wins on a collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      if (wr_en)    pending[waddr]    <= 1'b0;
      if (iss_fire) pending[iss_addr] <= 1'b1;
    end
  end

  // Pending counter: a clear only counts when it actually drops a set bit.
  // An accepted issue implies its bit was clear, so set+clear of one index
  // cannot both count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (iss_fire && !wb_clr) begin
      cnt <= cnt + 1'b1;
    end else if (!iss_fire && wb_clr) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign pend_cnt = cnt;
  assign idle     = (cnt == '0);

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    // Combinational read port k with optional writeback forwarding.
    always_comb begin
      rd_data[k*DATA_W +: DATA_W] = (ra == '0) ? '0 : regs[ra];
      rd_busy[k]                  = (ra != '0) && pending[ra];
`ifdef RISSY_RF_BYPASS_EN
      if (wr_en && (ra == waddr)) begin
        rd_data[k*DATA_W +: DATA_W] = wdata;
        rd_busy[k]                  = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_rissy_regfile_sb.sv
// Scoreboard bench for rissy_regfile_sb: each stimulus step pushes the
// expected combinational outputs; a monitor pops and compares on negedge.
module tb_rissy_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  rd_busy;
  logic        iss_valid;
  logic [2:0]  iss_addr;
  logic        iss_ready;
  logic [3:0]  pend_cnt;
  logic        idle;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rissy_regfile_sb #(.DATA_W(16), .ADDR_W(3), .NRD(2)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .pend_cnt(pend_cnt), .idle(idle)
  );

  // care bits: [0] rd_data [1] rd_busy [2] iss_ready [3] pend_cnt [4] idle
  typedef struct {
    string       name;
    logic [4:0]  care;
    logic [31:0] rdata;
    logic [1:0]  busy;
    logic        ready;
    logic [3:0]  pcnt;
    logic        idl;
  } exp_t;

  exp_t sb_q[$];

  task automatic drive(input logic r, input logic w, input logic [2:0] wa,
                       input logic [15:0] wd, input logic [2:0] a0,
                       input logic [2:0] a1, input logic iv,
                       input logic [2:0] ia);
    @(posedge clk);
    #1;
    rst       = r;
    we        = w;
    waddr     = wa;
    wdata     = wd;
    rd_addr   = {a1, a0};
    iss_valid = iv;
    iss_addr  = ia;
  endtask

  task automatic expect_out(input string nm, input logic [4:0] care,
                            input logic [31:0] rdata, input logic [1:0] busy,
                            input logic ready, input logic [3:0] pcnt,
                            input logic idl);
    exp_t e;
    e.name  = nm;
    e.care  = care;
    e.rdata = rdata;
    e.busy  = busy;
    e.ready = ready;
    e.pcnt  = pcnt;
    e.idl   = idl;
    sb_q.push_back(e);
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.care[0]) begin
          checks++;
          if (rd_data !== e.rdata) begin
            failures++;
            $display("FAIL %s rd_data got=%h exp=%h", e.name, rd_data, e.rdata);
          end
        end
        if (e.care[1]) begin
          checks++;
          if (rd_busy !== e.busy) begin
            failures++;
            $display("FAIL %s rd_busy got=%b exp=%b", e.name, rd_busy, e.busy);
          end
        end
        if (e.care[2]) begin
          checks++;
          if (iss_ready !== e.ready) begin
            failures++;
            $display("FAIL %s iss_ready got=%b exp=%b", e.name, iss_ready, e.ready);
          end
        end
        if (e.care[3]) begin
          checks++;
          if (pend_cnt !== e.pcnt) begin
            failures++;
            $display("FAIL %s pend_cnt got=%0d exp=%0d", e.name, pend_cnt, e.pcnt);
          end
        end
        if (e.care[4]) begin
          checks++;
          if (idle !== e.idl) begin
            failures++;
            $display("FAIL %s idle got=%b exp=%b", e.name, idle, e.idl);
          end
        end
      end
    end
  end

  localparam logic [4:0] ALL = 5'b11111;
  localparam logic [4:0] CTL = 5'b11100;

  logic [31:0] byp_data;
  logic [1:0]  byp_busy;

  initial begin
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; rd_addr = '0;
    iss_valid = 1'b0; iss_addr = '0;
    repeat (2) @(posedge clk);

    // Reset state
    drive(1, 0, 0, 16'h0000, 3, 5, 0, 0);
    expect_out("reset_state", ALL, 32'h0, 2'b00, 1, 4'd0, 1);

    // Register 0 is immutable
    drive(1, 1, 0, 16'hFFFF, 0, 0, 0, 0);
    expect_out("r0_write_pre", ALL, 32'h0, 2'b00, 1, 4'd0, 1);
    drive(1, 0, 0, 16'h0000, 0, 0, 1, 0);
    expect_out("r0_issue_pre", ALL, 32'h0, 2'b00, 1, 4'd0, 1);
    drive(1, 0, 0, 16'h0000, 0, 0, 0, 0);
    expect_out("r0_after", ALL, 32'h0, 2'b00, 1, 4'd0, 1);

    // WAW stall and writeback release on r2 (both ports on r2)
    drive(1, 0, 0, 16'h0000, 2, 2, 1, 2);
    expect_out("r2_issue1", ALL, 32'h0, 2'b00, 1, 4'd0, 1);
    drive(1, 0, 0, 16'h0000, 2, 2, 1, 2);
    expect_out("r2_issue2_stall", ALL, 32'h0, 2'b11, 0, 4'd1, 0);
    drive(1, 1, 2, 16'h1234, 3, 3, 0, 2);
    expect_out("r2_wb_pre", CTL, 32'h0, 2'b00, 0, 4'd1, 0);
    drive(1, 0, 0, 16'h0000, 2, 2, 0, 0);
    expect_out("r2_wb_after", ALL, 32'h1234_1234, 2'b00, 1, 4'd0, 1);

    // Same-edge writeback and accepted issue of r4: set wins
    drive(1, 1, 4, 16'h00AA, 3, 0, 1, 4);
    expect_out("r4_wb_iss_pre", CTL, 32'h0, 2'b00, 1, 4'd0, 1);
    drive(1, 0, 0, 16'h0000, 4, 0, 0, 4);
    expect_out("r4_set_wins", ALL, 32'h0000_00AA, 2'b01, 0, 4'd1, 0);
    // Issue r1 while r4 clears: net zero
    drive(1, 1, 4, 16'h0055, 3, 3, 1, 1);
    expect_out("r1_iss_r4_wb_pre", CTL, 32'h0, 2'b00, 1, 4'd1, 0);
    drive(1, 0, 0, 16'h0000, 1, 4, 0, 0);
    expect_out("net_zero", ALL, 32'h0055_0000, 2'b01, 1, 4'd1, 0);

    // Read of r6 during its own writeback
    drive(1, 0, 0, 16'h0000, 6, 6, 1, 6);
    expect_out("r6_issue", ALL, 32'h0, 2'b00, 1, 4'd1, 0);
`ifdef RISSY_RF_BYPASS_EN
    byp_data = 32'h0055_BEEF;
    byp_busy = 2'b00;
`else
    byp_data = 32'h0055_0000;
    byp_busy = 2'b01;
`endif
    drive(1, 1, 6, 16'hBEEF, 6, 4, 0, 6);
    expect_out("r6_wb_read", ALL, byp_data, byp_busy, 0, 4'd2, 0);
    drive(1, 0, 0, 16'h0000, 6, 6, 0, 0);
    expect_out("r6_after", ALL, 32'hBEEF_BEEF, 2'b00, 1, 4'd1, 0);

    // Release r1, then reserve r1, r2, r3
    drive(1, 1, 1, 16'h1111, 1, 1, 0, 0);
    expect_out("r1_wb_pre", CTL, 32'h0, 2'b00, 1, 4'd1, 0);
    drive(1, 0, 0, 16'h0000, 1, 1, 1, 1);
    expect_out("iss_r1", ALL, 32'h1111_1111, 2'b00, 1, 4'd0, 1);
    drive(1, 0, 0, 16'h0000, 1, 1, 1, 2);
    expect_out("iss_r2", CTL, 32'h0, 2'b00, 1, 4'd1, 0);
    drive(1, 0, 0, 16'h0000, 1, 1, 1, 3);
    expect_out("iss_r3", CTL, 32'h0, 2'b00, 1, 4'd2, 0);
    drive(1, 0, 0, 16'h0000, 1, 3, 0, 1);
    expect_out("three_pending", 5'b11110, 32'h0, 2'b11, 0, 4'd3, 0);

    // Mid-operation reset with ignored write and issue
    drive(0, 1, 7, 16'h7777, 1, 3, 1, 5);
    expect_out("rst_pre", 5'b11000, 32'h0, 2'b00, 0, 4'd3, 0);
    drive(1, 0, 0, 16'h0000, 2, 6, 0, 1);
    expect_out("rst_clears", ALL, 32'h0, 2'b00, 1, 4'd0, 1);
    drive(1, 0, 0, 16'h0000, 7, 5, 0, 5);
    expect_out("rst_ignored_wr", ALL, 32'h0, 2'b00, 1, 4'd0, 1);

    drive(1, 0, 0, 16'h0000, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain queue got=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
